// File: rtl/pe_grid_scheduler.sv
// Sequences one pass of the PE grid: loads one weight per active row, streams one
// image value per active column onto the multicast buses, drains, then strobes capture.
module pe_grid_scheduler #(
  parameter int ROWS         = 12,
  parameter int COLS         = 14,
  parameter int DATA_W       = 16,
  parameter int TAG_W        = 4,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [TAG_W-1:0]  num_rows,
  input  logic [TAG_W-1:0]  num_cols,
  input  logic [DATA_W-1:0] w_data,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              i_ready,
  output logic [DATA_W-1:0] weight_val_in,
  output logic [TAG_W-1:0]  tag_row,
  output logic              valid_y,
  output logic [DATA_W-1:0] image_val_in,
  output logic [TAG_W-1:0]  tag_col,
  output logic              valid_x,
  output logic              psum_capture,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD_W   = 3'd1;
  localparam logic [2:0] S_STREAM_I = 3'd2;
  localparam logic [2:0] S_DRAIN    = 3'd3;
  localparam logic [2:0] S_CAPTURE  = 3'd4;

  localparam logic [TAG_W-1:0] TAG_ZERO = {TAG_W{1'b0}};
  localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);

  logic [2:0]        state_q, state_d;
  logic [TAG_W-1:0]  idx_q, idx_d;
  logic [TAG_W-1:0]  rows_q, rows_d;
  logic [TAG_W-1:0]  cols_q, cols_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              w_ready_q, w_ready_d;
  logic              i_ready_q, i_ready_d;
  logic [DATA_W-1:0] wval_q, wval_d;
  logic [TAG_W-1:0]  tag_row_q, tag_row_d;
  logic              valid_y_q, valid_y_d;
  logic [DATA_W-1:0] ival_q, ival_d;
  logic [TAG_W-1:0]  tag_col_q, tag_col_d;
  logic              valid_x_q, valid_x_d;
  logic              capture_q, capture_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cfg_ok_s;

  assign cfg_ok_s = (num_rows != TAG_ZERO) && (32'(num_rows) <= 32'(ROWS)) &&
                    (num_cols != TAG_ZERO) && (32'(num_cols) <= 32'(COLS));

  // Next-state and bus-register logic; abort outranks any same-cycle handshake.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rows_d    = rows_q;
    cols_d    = cols_q;
    cnt_d     = cnt_q;
    wval_d    = wval_q;
    tag_row_d = tag_row_q;
    valid_y_d = 1'b0;
    ival_d    = ival_q;
    tag_col_d = tag_col_q;
    valid_x_d = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && cfg_ok_s) begin
          rows_d  = num_rows;
          cols_d  = num_cols;
          idx_d   = TAG_ZERO;
          state_d = S_LOAD_W;
        end else if (start) begin
          err_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_W: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (w_valid && w_ready_q) begin
          wval_d    = w_data;
          tag_row_d = idx_q;
          valid_y_d = 1'b1;
          if (idx_q == rows_q - TAG_ONE) begin
            idx_d   = TAG_ZERO;
            state_d = S_STREAM_I;
          end else begin
            idx_d = idx_q + TAG_ONE;
          end
        end else begin
          state_d = S_LOAD_W;
        end
      end
      S_STREAM_I: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (i_valid && i_ready_q) begin
          ival_d    = i_data;
          tag_col_d = idx_q;
          valid_x_d = 1'b1;
          if (idx_q == cols_q - TAG_ONE) begin
            idx_d   = TAG_ZERO;
            cnt_d   = CNT_W'(DRAIN_CYCLES);
            state_d = S_DRAIN;
          end else begin
            idx_d = idx_q + TAG_ONE;
          end
        end else begin
          state_d = S_STREAM_I;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_CAPTURE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    w_ready_d = (state_d == S_LOAD_W);
    i_ready_d = (state_d == S_STREAM_I);
    busy_d    = (state_d != S_IDLE);
    capture_d = (state_d == S_CAPTURE);
    done_d    = (state_d == S_CAPTURE);
  end

  // State and output registers; reset clears every output including data and tags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= TAG_ZERO;
      rows_q    <= TAG_ZERO;
      cols_q    <= TAG_ZERO;
      cnt_q     <= {CNT_W{1'b0}};
      w_ready_q <= 1'b0;
      i_ready_q <= 1'b0;
      wval_q    <= {DATA_W{1'b0}};
      tag_row_q <= TAG_ZERO;
      valid_y_q <= 1'b0;
      ival_q    <= {DATA_W{1'b0}};
      tag_col_q <= TAG_ZERO;
      valid_x_q <= 1'b0;
      capture_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rows_q    <= rows_d;
      cols_q    <= cols_d;
      cnt_q     <= cnt_d;
      w_ready_q <= w_ready_d;
      i_ready_q <= i_ready_d;
      wval_q    <= wval_d;
      tag_row_q <= tag_row_d;
      valid_y_q <= valid_y_d;
      ival_q    <= ival_d;
      tag_col_q <= tag_col_d;
      valid_x_q <= valid_x_d;
      capture_q <= capture_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign w_ready       = w_ready_q;
  assign i_ready       = i_ready_q;
  assign weight_val_in = wval_q;
  assign tag_row       = tag_row_q;
  assign valid_y       = valid_y_q;
  assign image_val_in  = ival_q;
  assign tag_col       = tag_col_q;
  assign valid_x       = valid_x_q;
  assign psum_capture  = capture_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule
